montar_senha: RTL

Keypad-side producer of the PIN packet: collects key events, assembles up to four digits into a `pinPac_t`, and issues the packet with `status` high for exactly one clock so the downstream password checker samples it once. Sits between the debounced keypad decoder and the password verification block; clearing, inactivity timeout and enable gating are handled here, so the checker only ever sees complete, single-shot submissions.

---
 rtl/montar_senha_pkg.sv | 43 ++++
 rtl/montar_senha_timer_inatividade.sv | 38 +++
 rtl/montar_senha.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/montar_senha_pkg.sv
// Shared keypad/PIN packet types.
// Used by montar_senha and the password checker.
package montar_senha_pkg;

  localparam logic [3:0] KEY_CLEAR   = 4'hA;
  localparam logic [3:0] KEY_ENTER   = 4'hB;
  localparam logic [3:0] DIGIT_EMPTY = 4'hF;

  typedef struct packed {
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic       status;
  } pinPac_t;

  typedef struct packed {
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic       status;
  } setupPac_t;

  localparam pinPac_t PIN_RST = '{
    DIGIT_EMPTY, DIGIT_EMPTY,
    DIGIT_EMPTY, DIGIT_EMPTY,
    1'b0
  };

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    SEND
  } entrada_state_t;

  function automatic logic is_digit(
    input logic [3:0] k
  );
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/montar_senha_timer_inatividade.sv
// Inactivity timer for a partial PIN entry.
// expire is high in the terminal count cycle only.
module timer_inatividade #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST =
    W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    expire = run && !restart && (cnt_q == LAST);
    if (!run || restart || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/montar_senha.sv
// Collects keypad digits into a PIN packet and
// issues it with a single-cycle status strobe.
module montar_senha
  import montar_senha_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output pinPac_t    pin_out,
  output logic [2:0] digit_count,
  output logic       entry_active,
  output logic       entry_timeout,
  output logic       digit_overflow
);

  entrada_state_t  state_q, state_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [2:0]      cnt_q, cnt_d;
  pinPac_t         pin_q, pin_d;
  logic            tmo_q, tmo_d;
  logic            ovf_q, ovf_d;

  logic kv;
  logic is_dig;
  logic is_clr;
  logic is_ent;
  logic run;
  logic restart;
  logic expire;

  assign kv      = key_valid && enable;
  assign is_dig  = is_digit(key_code);
  assign is_clr  = key_code == KEY_CLEAR;
  assign is_ent  = key_code == KEY_ENTER;
  assign run     = (state_q == ENTRY) && enable;
  assign restart = key_valid || (state_q != ENTRY);

  timer_inatividade #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .restart(restart),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dig_q   <= {4{DIGIT_EMPTY}};
      cnt_q   <= 3'd0;
      pin_q   <= PIN_RST;
      tmo_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (kv && is_dig) state_d = ENTRY;
      end
      ENTRY: begin
        unique case (1'b1)
          !enable:       state_d = IDLE;
          kv && is_clr:  state_d = IDLE;
          kv && is_ent:  state_d = SEND;
          expire:        state_d = IDLE;
          default:       state_d = ENTRY;
        endcase
      end
      SEND:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    pin_d      = pin_q;
    pin_d.status = 1'b0;
    tmo_d      = 1'b0;
    ovf_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (kv && is_dig) begin
          dig_d = {DIGIT_EMPTY, DIGIT_EMPTY,
                   DIGIT_EMPTY, key_code};
          cnt_d = 3'd1;
        end
      end
      ENTRY: begin
        unique case (1'b1)
          !enable, kv && is_clr: begin
            dig_d = {4{DIGIT_EMPTY}};
            cnt_d = 3'd0;
          end
          kv && is_dig && (cnt_q == 3'd4): begin
            ovf_d = 1'b1;
          end
          kv && is_dig && (cnt_q < 3'd4): begin
            dig_d = {dig_q[2:0], key_code};
            cnt_d = cnt_q + 3'd1;
          end
          kv && is_ent: begin
            pin_d.digit1 = dig_q[0];
            pin_d.digit2 = dig_q[1];
            pin_d.digit3 = dig_q[2];
            pin_d.digit4 = dig_q[3];
            pin_d.status = 1'b1;
          end
          expire: begin
            dig_d = {4{DIGIT_EMPTY}};
            cnt_d = 3'd0;
            tmo_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        dig_d = {4{DIGIT_EMPTY}};
        cnt_d = 3'd0;
      end
    endcase
  end

  assign pin_out        = pin_q;
  assign digit_count    = cnt_q;
  assign entry_active   = state_q == ENTRY;
  assign entry_timeout  = tmo_q;
  assign digit_overflow = ovf_q;

endmodule
